// File: rtl/counter_event_monitor_if.sv
// rtl/counter_event_monitor_if.sv - event record read port (valid/ready) of counter_event_monitor
interface counter_event_monitor_if;
    logic        evt_valid;
    logic        evt_ready;
    logic [6:0]  evt_code;
    logic [7:0]  evt_value_1;
    logic [7:0]  evt_value_2;
    logic [15:0] evt_stamp;

    modport master (
        output evt_valid, evt_code, evt_value_1, evt_value_2, evt_stamp,
        input  evt_ready
    );

    modport slave (
        input  evt_valid, evt_code, evt_value_1, evt_value_2, evt_stamp,
        output evt_ready
    );
endinterface

// File: rtl/counter_event_monitor.sv
// rtl/counter_event_monitor.sv - wrap/match/threshold event detector feeding a timestamped show-ahead FIFO
// Optional threshold-crossing events (Evt_Code[6:5]) are built only with COUNTER_EVT_THRESH_EN defined.
module counter_event_monitor #(
    parameter int         DEPTH  = 8,
    parameter logic [7:0] THRESH = 8'hC0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               cnt_data_1,
    input  logic [7:0]               cnt_data_2,
    input  logic                     mon_enable,
    input  logic                     ovf_clear,
    counter_event_monitor_if.master  evt,
    output logic [$clog2(DEPTH):0]   evt_count,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [6:0]  code;
        logic [7:0]  value_1;
        logic [7:0]  value_2;
        logic [15:0] stamp;
    } rec_t;

    rec_t          mem [DEPTH];
    rec_t          head;
    logic [7:0]    prev_1;
    logic [7:0]    prev_2;
    logic          primed;
    logic [15:0]   stamp;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [6:0]    mask;
    logic          valid;
    logic          full;
    logic          push;
    logic          pop;
    logic          accept;
    logic          lost;

    always_comb begin
        mask    = '0;
        mask[0] = (prev_1 == 8'hFF) && (cnt_data_1 == 8'h00);
        mask[1] = (prev_1 == 8'h00) && (cnt_data_1 == 8'hFF);
        mask[2] = (prev_2 == 8'hFF) && (cnt_data_2 == 8'h00);
        mask[3] = (prev_2 == 8'h00) && (cnt_data_2 == 8'hFF);
        mask[4] = (cnt_data_1 == cnt_data_2) && (prev_1 != prev_2);
`ifdef COUNTER_EVT_THRESH_EN
        mask[5] = (prev_1 < THRESH) && (cnt_data_1 >= THRESH);
        mask[6] = (prev_2 < THRESH) && (cnt_data_2 >= THRESH);
`endif
    end

`ifndef COUNTER_EVT_THRESH_EN
    logic unused_thresh;
    assign unused_thresh = ^THRESH;
`endif

    assign valid  = (count != '0);
    assign full   = (count == FULL_CNT);
    assign push   = mon_enable & primed & (|mask);
    // Pop is qualified by valid, so an empty-FIFO push+pop never falls through.
    assign pop    = valid & evt.evt_ready;
    assign accept = push & (~full | pop);
    assign lost   = push & full & ~pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_1   <= '0;
            prev_2   <= '0;
            primed   <= 1'b0;
            stamp    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            prev_1 <= cnt_data_1;
            prev_2 <= cnt_data_2;
            primed <= mon_enable;
            stamp  <= stamp + 16'd1;
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
            case ({accept, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
            if (lost)           overflow <= 1'b1;
            else if (ovf_clear) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= {mask, cnt_data_1, cnt_data_2, stamp};
    end

    // Head fields are gated so stale storage never shows while empty or in reset.
    assign head            = mem[rd_ptr];
    assign evt.evt_valid   = valid;
    assign evt.evt_code    = valid ? head.code    : '0;
    assign evt.evt_value_1 = valid ? head.value_1 : '0;
    assign evt.evt_value_2 = valid ? head.value_2 : '0;
    assign evt.evt_stamp   = valid ? head.stamp   : '0;
    assign evt_count       = count;
endmodule

// File: doc/counter_event_monitor.md
Name: counter_event_monitor

Overview:
- Downstream stage of the dual up/down counter top. Watches both 8-bit counter outputs every cycle.
- Detects wrap-around, counter-match and (optionally) threshold-crossing events.
- Stores each event as a timestamped record in a show-ahead FIFO that the bench or a CPU-side reader drains through a valid/ready handshake.

Parameters:
DEPTH, 8, FIFO entries; power of 2, minimum 2.
THRESH, 8'hC0, threshold for the optional crossing event.

Ports:
Clk  input  1  clock; all state changes on the rising edge.
Reset  input  1  reset, asynchronous and active-low (one clock; reset is asynchronous and active-low).
Cnt_Data_1  input  8  counter 1 value (from Out_Data_1).
Cnt_Data_2  input  8  counter 2 value (from Out_Data_2).
Mon_Enable  input  1  monitoring enable.
Ovf_Clear  input  1  clears the sticky Overflow flag.
Evt_Ready  input  1  reader accepts the head record.
Evt_Valid  output  1  FIFO not empty; head record valid.
Evt_Code  output  7  event bitmask of the head record.
Evt_Value_1  output  8  counter 1 value at the event.
Evt_Value_2  output  8  counter 2 value at the event.
Evt_Stamp  output  16  cycle stamp at the event.
Evt_Count  output  $clog2(DEPTH)+1  FIFO occupancy.
Overflow  output  1  sticky; set when an event is lost.

Behaviour:
- Reset asserted (Reset==0):
  - Prev_1, Prev_2, stamp counter, Primed, FIFO pointers and Overflow clear immediately.
  - All outputs read 0: Evt_Valid=0, Evt_Count=0.
  - FIFO contents are discarded.
  - Reset asserted mid-operation drops all queued records.
- Stamp counter:
  - 16-bit, increments every cycle, independent of Mon_Enable.
  - Wraps 16'hFFFF to 16'h0000.
- Previous-value registers:
  - Prev_1 <= Cnt_Data_1 and Prev_2 <= Cnt_Data_2 every cycle.
  - Primed <= Mon_Enable every cycle.
  - The first enabled cycle therefore compares against a stale value and is ignored.
- Event mask, combinational on the current inputs versus Prev:
  - bit0 WRAP_UP_1: Prev_1==8'hFF and Cnt_Data_1==8'h00.
  - bit1 WRAP_DN_1: Prev_1==8'h00 and Cnt_Data_1==8'hFF.
  - bit2 WRAP_UP_2 and bit3 WRAP_DN_2: same rules for counter 2.
  - bit4 MATCH: Cnt_Data_1==Cnt_Data_2 and Prev_1!=Prev_2, i.e. rising edge of equality only.
  - bits6:5: see Optional Feature.
  - Several bits may be set in one record; there is no priority and nothing is dropped within a cycle.
  - A load that jumps FF->00 counts as a wrap. The rule is value-based only.
- Push: Mon_Enable & Primed & (mask!=0).
  - Record = {mask, Cnt_Data_1, Cnt_Data_2, stamp value of that cycle}.
- Pop: Evt_Valid & Evt_Ready. Pop when empty is a no-op.
- Latency:
  - An event sampled at edge N is pushed at edge N.
  - Evt_Valid rises after edge N, i.e. one cycle of latency, if the FIFO was empty.
  - Head outputs are stable while Evt_Valid=1 and Evt_Ready=0.
- Full (Evt_Count==DEPTH):
  - Push without pop: record dropped, Overflow set at that edge.
  - Push with pop in the same cycle: push accepted, count stays DEPTH, no overflow.
- Empty with push and pop in the same cycle: the pop is ignored and the push is accepted. This is not a fall-through FIFO.
- Overflow is sticky and clears only on Ovf_Clear=1. If Ovf_Clear and a new overflow occur in the same cycle, the set wins.
- Evt_Count changes by +1, -1 or 0 per cycle, never more.
- Mon_Enable low: no pushes; pops continue so the reader can drain.

Optional Feature:
- Macro: COUNTER_EVT_THRESH_EN.
- Defined:
  - Evt_Code bit5 THR_1: Prev_1<THRESH and Cnt_Data_1>=THRESH, unsigned.
  - Bit6 THR_2: same rule for counter 2.
  - Downward crossings are not reported.
- Undefined:
  - Evt_Code[6:5] tied to 0.
  - No threshold compare logic is present.
  - Port list is unchanged.

Test Plan:
- Reset with Cnt_Data_1=8'h05, then Reset=0 mid-stream with 3 records queued -> Evt_Valid=0, Evt_Count=0, Overflow=0 immediately; records are gone after release.
- Counter 1 counts up FE,FF,00,01 with Mon_Enable=1 and Evt_Ready=0 -> one record: Evt_Code=7'h01, Evt_Value_1=8'h00, Evt_Stamp = cycle of the 00 sample; Evt_Valid one cycle later.
- Counter 1 counts up 10->11 and counter 2 counts down 12->11 in the same cycle -> single record with Evt_Code=7'h10 and both values 8'h11. Holding both at 8'h11 afterwards produces no further records.
- Force 9 wrap events with Evt_Ready=0 and DEPTH=8 -> Evt_Count=8, Overflow=1. Draining yields the first 8 stamps in order. Ovf_Clear=1 then clears Overflow.
- Full FIFO with a push and Evt_Ready=1 in the same cycle -> Evt_Count stays 8, Overflow stays 0, and the new record is last out.
- With COUNTER_EVT_THRESH_EN, counter 2 counts BF->C0 -> Evt_Code=7'h40. Counting C0->BF gives no record. Without the macro, BF->C0 gives no record.
